instr_exec_ctrl: RTL

INSTR_EXEC_CTRL -- requirements
Module: instr_exec_ctrl

---
 rtl/instr_exec_ctrl_if.sv | 57 +++++
 rtl/instr_exec_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// instr_exec_ctrl_if
//
// Purpose: bundles the decoded-instruction handshake, the matrix memory bus
// and the ALU launch/complete handshake of instr_exec_ctrl into one
// interface.
//
// Signals:
//   start       decoded instruction valid (single-cycle pulse)
//   opcode[3:0] decoded opcode
//   adrs[7:0]   decoded matrix memory address
//   data[15:0]  decoded write data or scalar (scalar in [7:0])
//   busy        instruction in progress
//   done        one-cycle completion pulse
//   error       last accepted instruction was illegal or timed out
//   mem_addr    matrix memory address
//   mem_wdata   memory write data
//   mem_we      memory write enable
//   mem_rdata   memory read data
//   rd_data     captured LOAD result
//   alu_start   one-cycle ALU launch pulse
//   alu_op      latched opcode for the ALU
//   alu_scalar  latched scalar for the ALU
//   alu_done    ALU completion pulse
//
// Modports: slave = controller side, master = decoder/memory/ALU side.
// ---------------------------------------------------------------------------
interface instr_exec_ctrl_if;
    logic        start;
    logic [3:0]  opcode;
    logic [7:0]  adrs;
    logic [15:0] data;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] rd_data;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [7:0]  alu_scalar;
    logic        alu_done;

    modport slave (
        input  start, opcode, adrs, data, mem_rdata, alu_done,
        output busy, done, error, mem_addr, mem_wdata, mem_we,
               rd_data, alu_start, alu_op, alu_scalar
    );

    modport master (
        output start, opcode, adrs, data, mem_rdata, alu_done,
        input  busy, done, error, mem_addr, mem_wdata, mem_we,
               rd_data, alu_start, alu_op, alu_scalar
    );
endinterface

// File: rtl/instr_exec_ctrl.sv
// ---------------------------------------------------------------------------
// instr_exec_ctrl
//
// Purpose: executes one decoded instruction at a time. NOP completes
// directly, STORE issues a single-cycle memory write, LOAD issues a read and
// captures the data MEM_LATENCY cycles later, and 1xxx opcodes launch the
// external ALU and wait for its completion pulse. Opcodes 0011-0111 are
// illegal and only raise error. Every instruction ends with a one-cycle
// done pulse.
//
// Parameters:
//   MEM_LATENCY  cycles from mem_addr valid to mem_rdata valid (1-15)
//   ALU_TIMEOUT  maximum ALU wait cycles (timeout build only)
//
// Ports:
//   clk      single clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      instr_exec_ctrl_if.slave (instruction, memory and ALU signals)
//
// Configuration macro:
//   EXEC_TIMEOUT_EN  when defined, ALU_WAIT gives up after ALU_TIMEOUT
//                    cycles without alu_done, flags error and completes.
//                    When undefined, ALU_WAIT waits for alu_done forever.
// ---------------------------------------------------------------------------
module instr_exec_ctrl #(
    parameter int MEM_LATENCY = 2,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_exec_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        LOAD_WAIT,
        ALU_WAIT,
        DONE
    } ExecState;

    // One wait counter serves both the load latency and the ALU timeout, so
    // it is sized for whichever of the two limits is larger.
    localparam int CNT_W = (ALU_TIMEOUT > 15) ? $clog2(ALU_TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(MEM_LATENCY - 1);
`ifdef EXEC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ALU_LAST  = CNT_W'(ALU_TIMEOUT - 1);
`endif

    ExecState         r_state;
    logic [3:0]       r_opcode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [7:0]       r_memAddr;
    logic [15:0]      r_memWdata;
    logic             r_memWe;
    logic [15:0]      r_rdData;
    logic             r_aluStart;
    logic [3:0]       r_aluOp;
    logic [7:0]       r_aluScalar;

    // Decode of the incoming opcode is needed at acceptance because mem_we
    // and alu_start are registered and must already be high in EXEC.
    logic w_inLoad;
    logic w_inStore;
    logic w_inAlu;
    logic w_isLoad;
    logic w_isAlu;
    logic w_isIllegal;

    assign w_inLoad    = (bus.opcode == 4'b0001);
    assign w_inStore   = (bus.opcode == 4'b0010);
    assign w_inAlu     = bus.opcode[3];
    assign w_isLoad    = (r_opcode == 4'b0001);
    assign w_isAlu     = r_opcode[3];
    assign w_isIllegal = !r_opcode[3] && (r_opcode[2:0] >= 3'd3);

    // Single state machine with every output registered. Accepting an
    // instruction preloads the EXEC-cycle strobes; EXEC clears them and
    // dispatches; the wait states finish by raising done for the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_opcode    <= 4'd0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_memAddr   <= 8'd0;
            r_memWdata  <= 16'd0;
            r_memWe     <= 1'b0;
            r_rdData    <= 16'd0;
            r_aluStart  <= 1'b0;
            r_aluOp     <= 4'd0;
            r_aluScalar <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_opcode <= bus.opcode;
                        r_busy   <= 1'b1;
                        r_error  <= 1'b0;
                        r_state  <= EXEC;
                        if (w_inLoad || w_inStore) begin
                            r_memAddr <= bus.adrs;
                        end
                        if (w_inStore) begin
                            r_memWdata <= bus.data;
                            r_memWe    <= 1'b1;
                        end
                        if (w_inAlu) begin
                            r_aluStart  <= 1'b1;
                            r_aluOp     <= bus.opcode;
                            r_aluScalar <= bus.data[7:0];
                        end
                    end
                end
                EXEC: begin
                    r_memWe    <= 1'b0;
                    r_aluStart <= 1'b0;
                    r_cnt      <= '0;
                    if (w_isLoad) begin
                        r_state <= LOAD_WAIT;
                    end else if (w_isAlu) begin
                        r_state <= ALU_WAIT;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                        if (w_isIllegal) begin
                            r_error <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // mem_addr went out in EXEC, so the data is valid in the
                    // last of MEM_LATENCY wait cycles.
                    if (r_cnt == LOAD_LAST) begin
                        r_rdData <= bus.mem_rdata;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ALU_WAIT: begin
                    if (bus.alu_done) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
`ifdef EXEC_TIMEOUT_EN
                    end else if (r_cnt == ALU_LAST) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.mem_addr   = r_memAddr;
    assign bus.mem_wdata  = r_memWdata;
    assign bus.mem_we     = r_memWe;
    assign bus.rd_data    = r_rdData;
    assign bus.alu_start  = r_aluStart;
    assign bus.alu_op     = r_aluOp;
    assign bus.alu_scalar = r_aluScalar;

endmodule
